alu_instr_sequencer: RTL
========================

Name: alu_instr_sequencer

Overview:
Hardwired control sequencer for the bus-based datapath. It replaces hand-driven T-state stimulus with a parametrised FSM. Per instruction it fetches (PC→MAR, PC+1 via ALU INC, memory read→MDR→IR), decodes the IR, and executes one 3-operand R-type ALU instruction, emitting every one-hot datapath control strobe. It is generalised in register count and field widths, and adds a memory-ready handshake and illegal-instruction detection.

Parameters:
NUM_REGS, 16, number of general registers; reg_out/reg_in width
REG_SEL_W, 4, width of each Ra/Rb/Rc IR field
OPCODE_W, 5, width of IR opcode field and alu_op
IR_W, 32, instruction width
INC_OP, 5'b11111, ALU opcode used for PC increment in T0

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-high reset
start  in  1  begin one instruction; sampled only in IDLE
mem_ready  in  1  memory data valid; T2 waits while low
ir  in  IR_W  current IR contents from datapath
busy  out  1  high in any state except IDLE
done  out  1  1-cycle pulse in writeback state
illegal  out  1  1-cycle pulse on undecodable instruction
pc_out, mar_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in  out  1 each  datapath strobes
zlow_in, zlow_out, zhigh_in, zhigh_out, hi_in, lo_in  out  1 each  datapath strobes
reg_out  out  NUM_REGS  one-hot register-to-bus enable
reg_in  out  NUM_REGS  one-hot register load enable
alu_op  out  OPCODE_W  ALU operation select

Behaviour:
- Clock `clock`, reset `clear`: single clock domain; asynchronous, active-high reset.
- On clear: state=IDLE; all outputs 0 (alu_op=0). Reset mid-instruction aborts immediately. No partial writeback follows, and the next start restarts from T0.
- Moore FSM: outputs decode only from the state register plus registered fields. No output depends combinationally on start or mem_ready.
- IR fields: opcode=ir[IR_W-1 -: OPCODE_W], Ra next REG_SEL_W bits, then Rb, then Rc.
- Each field is captured into internal registers at the T3→T4 edge, so later ir changes are ignored.
- States and asserted outputs:
  IDLE: none. start=1 → T0.
  T0: pc_out, mar_in, zlow_in, alu_op=INC_OP. → T1.
  T1: zlow_out, pc_in. → T2.
  T2: read, mdr_in. mem_ready=1 → T3; otherwise stay in T2, holding read/mdr_in.
  T3: mdr_out, ir_in. → T4.
  T4: reg_out[Rb], y_in. If decode is illegal: → ILL, with reg_out=0 in this cycle.
  T5: reg_out[Rc], zlow_in, alu_op=opcode. → T6.
  T6: zlow_out, reg_in[Ra], done. → IDLE.
  ILL: illegal=1; no reg_in. → IDLE.
- Legal decode: opcode in 5'b00011..5'b01011 inclusive, and Ra, Rb, Rc all < NUM_REGS. Decode is evaluated from the fields latched at the T3→T4 edge.
- Latency with mem_ready tied high: start sampled at edge k; T0 during cycle k+1; done during cycle k+7. Each low-mem_ready cycle in T2 adds one cycle.
- start during a non-IDLE state is ignored (no queueing).
- Ra==Rb or Ra==Rc is permitted: Ra is written only in T6, after operands are consumed.
- reg_out and reg_in are always zero or one-hot; never more than one bus driver per cycle.

Optional Feature:
Macro SEQ_MULDIV_EN.
- Defined: opcodes 5'b01111 (MUL) and 5'b10000 (DIV) are also legal, with Rb, Rc operands and Ra ignored. Sequence:
  - T5: zhigh_in and zlow_in both asserted.
  - T6: zlow_out, lo_in.
  - T7: zhigh_out, hi_in, done. → IDLE.
  - Latency +1 cycle.
- Undefined: these opcodes go to ILL; T7 does not exist; zhigh_in, zhigh_out, hi_in and lo_in are tied 0.

Test Plan:
- AND: mem_ready=1, ir=0x2A1B8000, start pulse → T0 pc_out/mar_in/alu_op=11111; T4 reg_out=0x0008; T5 reg_out=0x0080, alu_op=00101; T6 reg_in=0x0010, done; busy for 7 cycles.
- OR: ir=0x321B8000 → identical sequence with T5 alu_op=00110; R4=0x22|0x24=0x26 in the datapath.
- Handshake: mem_ready low for 3 cycles in T2 → read=mdr_in=1 for 4 cycles; done arrives 3 cycles later than nominal.
- Illegal: ir=0xF8000000 (opcode 11111) → illegal pulse after T4; reg_in never asserted; returns to IDLE.
- Reset: assert clear during T5 → all outputs 0 asynchronously; next start gives a full, correct sequence from T0.
- SEQ_MULDIV_EN: ir opcode 01111, Rb=r3, Rc=r7 → T5 zhigh_in=zlow_in=1; T6 lo_in; T7 hi_in and done. Without the macro, the same ir gives an illegal pulse.

Source files
------------

// File: rtl/alu_instr_sequencer_if.sv
// Control/handshake bundle between alu_instr_sequencer and the bus datapath.
// master: the sequencer (reads start/mem_ready/ir, drives strobes).
// slave : the datapath or testbench side.
interface alu_instr_sequencer_if #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned OPCODE_W = 5,
    parameter int unsigned IR_W     = 32
);
    logic                start;
    logic                mem_ready;
    logic [IR_W-1:0]     ir;
    logic                busy;
    logic                done;
    logic                illegal;
    logic                pc_out;
    logic                mar_in;
    logic                pc_in;
    logic                read;
    logic                mdr_in;
    logic                mdr_out;
    logic                ir_in;
    logic                y_in;
    logic                zlow_in;
    logic                zlow_out;
    logic                zhigh_in;
    logic                zhigh_out;
    logic                hi_in;
    logic                lo_in;
    logic [NUM_REGS-1:0] reg_out;
    logic [NUM_REGS-1:0] reg_in;
    logic [OPCODE_W-1:0] alu_op;

    modport master (
        input  start, mem_ready, ir,
        output busy, done, illegal, pc_out, mar_in, pc_in, read, mdr_in, mdr_out,
               ir_in, y_in, zlow_in, zlow_out, zhigh_in, zhigh_out, hi_in, lo_in,
               reg_out, reg_in, alu_op
    );

    modport slave (
        output start, mem_ready, ir,
        input  busy, done, illegal, pc_out, mar_in, pc_in, read, mdr_in, mdr_out,
               ir_in, y_in, zlow_in, zlow_out, zhigh_in, zhigh_out, hi_in, lo_in,
               reg_out, reg_in, alu_op
    );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the bus datapath.
// Runs one R-type ALU instruction per start pulse: T0-T3 fetch, T4-T6 execute,
// ILL on an undecodable instruction. All strobes are registered (Moore).
// Optional feature macro: SEQ_MULDIV_EN adds MUL/DIV with a T7 HI writeback.
module alu_instr_sequencer #(
    parameter int unsigned         NUM_REGS  = 16,
    parameter int unsigned         REG_SEL_W = 4,
    parameter int unsigned         OPCODE_W  = 5,
    parameter int unsigned         IR_W      = 32,
    parameter logic [OPCODE_W-1:0] INC_OP    = OPCODE_W'(5'b11111)
) (
    input logic                   clock,
    input logic                   clear,
    alu_instr_sequencer_if.master bus
);
    localparam int unsigned OP_LSB = IR_W - OPCODE_W;
    localparam int unsigned RA_LSB = OP_LSB - REG_SEL_W;
    localparam int unsigned RB_LSB = RA_LSB - REG_SEL_W;
    localparam int unsigned RC_LSB = RB_LSB - REG_SEL_W;

    localparam logic [OPCODE_W-1:0] OP_FIRST = OPCODE_W'(5'b00011);
    localparam logic [OPCODE_W-1:0] OP_LAST  = OPCODE_W'(5'b01011);
`ifdef SEQ_MULDIV_EN
    localparam logic [OPCODE_W-1:0] OP_MUL   = OPCODE_W'(5'b01111);
    localparam logic [OPCODE_W-1:0] OP_DIV   = OPCODE_W'(5'b10000);
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_ILL
`ifdef SEQ_MULDIV_EN
        , S_T7
`endif
    } state_t;

    typedef struct packed {
        logic                busy;
        logic                done;
        logic                illegal;
        logic                pc_out;
        logic                mar_in;
        logic                pc_in;
        logic                read;
        logic                mdr_in;
        logic                mdr_out;
        logic                ir_in;
        logic                y_in;
        logic                zlow_in;
        logic                zlow_out;
        logic                zhigh_in;
        logic                zhigh_out;
        logic                hi_in;
        logic                lo_in;
        logic [NUM_REGS-1:0] reg_out;
        logic [NUM_REGS-1:0] reg_in;
        logic [OPCODE_W-1:0] alu_op;
    } ctl_t;

    state_t               state_q, state_d;
    ctl_t                 ctl_q, ctl_d;
    logic [OPCODE_W-1:0]  op_q, op_n;
    logic [REG_SEL_W-1:0] ra_q, rb_q, rc_q, ra_n, rb_n, rc_n;
    logic                 legal_n;
`ifdef SEQ_MULDIV_EN
    logic                 muldiv_n;
`endif

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction

    // Low IR bits carry no fields; fold them so they read as intentionally unused.
    if (RC_LSB > 0) begin : g_ir_tail
        logic unused_ir_tail;
        assign unused_ir_tail = ^bus.ir[RC_LSB-1:0];
    end

    // Field view for the next cycle: live IR on the T3->T4 edge, latched copy after.
    always_comb begin
        op_n = op_q;
        ra_n = ra_q;
        rb_n = rb_q;
        rc_n = rc_q;
        if (state_q == S_T3) begin
            op_n = bus.ir[IR_W-1 -: OPCODE_W];
            ra_n = bus.ir[OP_LSB-1 -: REG_SEL_W];
            rb_n = bus.ir[RA_LSB-1 -: REG_SEL_W];
            rc_n = bus.ir[RB_LSB-1 -: REG_SEL_W];
        end
    end

    // Instruction decode on the field view.
    always_comb begin
        legal_n = (op_n >= OP_FIRST) && (op_n <= OP_LAST);
`ifdef SEQ_MULDIV_EN
        muldiv_n = (op_n == OP_MUL) || (op_n == OP_DIV);
        legal_n  = legal_n || muldiv_n;
`endif
        legal_n = legal_n && (32'(ra_n) < NUM_REGS) && (32'(rb_n) < NUM_REGS)
                          && (32'(rc_n) < NUM_REGS);
    end

    // Next state and the strobes that state will present.
    always_comb begin
        state_d = state_q;
        ctl_d   = '0;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    if (bus.mem_ready) state_d = S_T3;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = legal_n ? S_T5 : S_ILL;
            S_T5:    state_d = S_T6;
`ifdef SEQ_MULDIV_EN
            S_T6:    state_d = muldiv_n ? S_T7 : S_IDLE;
            S_T7:    state_d = S_IDLE;
`else
            S_T6:    state_d = S_IDLE;
`endif
            S_ILL:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ctl_d.busy = (state_d != S_IDLE);
        case (state_d)
            S_T0: begin
                ctl_d.pc_out  = 1'b1;
                ctl_d.mar_in  = 1'b1;
                ctl_d.zlow_in = 1'b1;
                ctl_d.alu_op  = INC_OP;
            end
            S_T1: begin
                ctl_d.zlow_out = 1'b1;
                ctl_d.pc_in    = 1'b1;
            end
            S_T2: begin
                ctl_d.read   = 1'b1;
                ctl_d.mdr_in = 1'b1;
            end
            S_T3: begin
                ctl_d.mdr_out = 1'b1;
                ctl_d.ir_in   = 1'b1;
            end
            S_T4: begin
                ctl_d.y_in    = 1'b1;
                ctl_d.reg_out = legal_n ? onehot(rb_n) : '0;
            end
            S_T5: begin
                ctl_d.reg_out = onehot(rc_n);
                ctl_d.zlow_in = 1'b1;
                ctl_d.alu_op  = op_n;
`ifdef SEQ_MULDIV_EN
                ctl_d.zhigh_in = muldiv_n;
`endif
            end
            S_T6: begin
                ctl_d.zlow_out = 1'b1;
`ifdef SEQ_MULDIV_EN
                if (muldiv_n) begin
                    ctl_d.lo_in = 1'b1;
                end else begin
                    ctl_d.reg_in = onehot(ra_n);
                    ctl_d.done   = 1'b1;
                end
`else
                ctl_d.reg_in = onehot(ra_n);
                ctl_d.done   = 1'b1;
`endif
            end
`ifdef SEQ_MULDIV_EN
            S_T7: begin
                ctl_d.zhigh_out = 1'b1;
                ctl_d.hi_in     = 1'b1;
                ctl_d.done      = 1'b1;
            end
`endif
            S_ILL:   ctl_d.illegal = 1'b1;
            default: ;
        endcase
    end

    // State and registered strobes.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
        end
    end

    // Instruction fields held from the T3->T4 edge onward.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            op_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
            rc_q <= '0;
        end else if (state_q == S_T3) begin
            op_q <= op_n;
            ra_q <= ra_n;
            rb_q <= rb_n;
            rc_q <= rc_n;
        end
    end

    assign bus.busy      = ctl_q.busy;
    assign bus.done      = ctl_q.done;
    assign bus.illegal   = ctl_q.illegal;
    assign bus.pc_out    = ctl_q.pc_out;
    assign bus.mar_in    = ctl_q.mar_in;
    assign bus.pc_in     = ctl_q.pc_in;
    assign bus.read      = ctl_q.read;
    assign bus.mdr_in    = ctl_q.mdr_in;
    assign bus.mdr_out   = ctl_q.mdr_out;
    assign bus.ir_in     = ctl_q.ir_in;
    assign bus.y_in      = ctl_q.y_in;
    assign bus.zlow_in   = ctl_q.zlow_in;
    assign bus.zlow_out  = ctl_q.zlow_out;
    assign bus.zhigh_in  = ctl_q.zhigh_in;
    assign bus.zhigh_out = ctl_q.zhigh_out;
    assign bus.hi_in     = ctl_q.hi_in;
    assign bus.lo_in     = ctl_q.lo_in;
    assign bus.reg_out   = ctl_q.reg_out;
    assign bus.reg_in    = ctl_q.reg_in;
    assign bus.alu_op    = ctl_q.alu_op;
endmodule
